instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: level-sampled run request, honoured only in IDLE or HALT.
REQ-004 SHALL have port Instruction, input, 8 bits: combinational read data from program memory at address PC.
REQ-005 SHALL have port zero_flag, input, 1 bit: datapath zero flag, sampled only in DECODE.
REQ-006 SHALL have port exec_ready, input, 1 bit: datapath accepts the current exec transfer.
REQ-007 SHALL have port PC, output, 4 bits: program-memory address, registered.
REQ-008 SHALL have port IR, output, 8 bits: instruction register, registered.
REQ-009 SHALL have port exec_valid, output, 1 bit: IR holds a datapath op awaiting acceptance.
REQ-010 SHALL have port halted, output, 1 bit: high exactly while in HALT.
REQ-011 SHALL have port busy, output, 1 bit: high in FETCH, DECODE or EXEC.

Function
REQ-012 SHALL use states IDLE, FETCH, DECODE, EXEC and HALT, with state encoding internal.
REQ-013 SHALL decode IR[7:4] as opcode and IR[3:0] as operand address.
REQ-014 SHALL decode opcodes as follows: 0000 NOP, 1101 JZ, 1110 JMP, 1111 HLT; all other opcodes are datapath ops.
REQ-015 In IDLE with start=1, SHALL go to FETCH next cycle; PC is unchanged.
REQ-016 In FETCH, SHALL load IR <= Instruction (memory read at current PC) and go to DECODE; fetch latency is 1 cycle.
REQ-017 In DECODE with NOP, SHALL set PC <= PC+1 and go to FETCH.
REQ-018 In DECODE with JMP, SHALL set PC <= IR[3:0] and go to FETCH.
REQ-019 In DECODE with JZ, SHALL set PC <= IR[3:0] if zero_flag=1, else PC <= PC+1, and go to FETCH.
REQ-020 In DECODE with HLT, SHALL leave PC unchanged and go to HALT.
REQ-021 In DECODE with a datapath op, SHALL go to EXEC, leaving PC unchanged.
REQ-022 SHALL drive exec_valid=1 throughout EXEC and 0 in all other states.
REQ-023 SHALL hold IR stable while exec_valid=1.
REQ-024 In EXEC, when exec_valid=1 and exec_ready=1 in the same cycle (handshake), SHALL set PC <= PC+1 and go to FETCH; otherwise it remains in EXEC indefinitely.
REQ-025 SHALL ignore exec_ready outside EXEC.
REQ-026 SHALL compute PC increment modulo 16 (15 -> 0 wrap, no flag).
REQ-027 In HALT with start=1, SHALL set PC <= 0 and go to FETCH; otherwise it remains in HALT.
REQ-028 SHALL ignore start in FETCH, DECODE and EXEC.
REQ-029 SHALL run each instruction in the minimum cycles below: NOP/JMP/JZ/HLT take 2 cycles (FETCH+DECODE); a datapath op takes 3 cycles with exec_ready already high.

Reset
REQ-030 With rst=1 at a rising edge, SHALL set state=IDLE, PC=0, IR=8'h00, exec_valid=0, halted=0, busy=0.
REQ-031 SHALL give rst priority over start and exec_ready, and over any state.
REQ-032 A reset asserted mid-EXEC SHALL drop exec_valid the cycle after the reset edge, with no PC increment.
REQ-033 SHALL keep outputs at their reset values while rst stays high.

Verification
REQ-034 Program {0:8'h12, 1:8'h00, 2:8'hF0}, exec_ready=1, pulse start -> one exec_valid pulse with IR=8'h12; PC sequence 0,1,2; halted=1 by cycle 8 after start; PC stays 2.
REQ-035 Program {0:8'hE5, 5:8'hD9, 9:8'hF0}, zero_flag=1 -> PC 0 -> 5 -> 9, then HALT; repeat with zero_flag=0 -> PC 0 -> 5 -> 6.
REQ-036 Datapath op at PC=3, exec_ready low for 4 cycles then high -> exec_valid high 5 cycles, IR constant, PC becomes 4 only after the handshake cycle.
REQ-037 PC=15 holding NOP, memory 0 = HLT -> PC wraps to 0, then HALT.
REQ-038 rst asserted during EXEC with exec_ready=0 -> next cycle exec_valid=0, PC=0, IR=8'h00, state IDLE; start afterwards fetches address 0.
REQ-039 In HALT, start=1 -> PC=0 and fetch resumes from address 0; start asserted during FETCH/EXEC has no effect.

Source files
------------

// File: rtl/instruction_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_sequencer
//
// Fetch/decode/execute controller for a small 16-word program memory.
// Control-flow opcodes (NOP, JZ, JMP, HLT) are resolved here. Every other
// opcode is handed to the datapath through a valid/ready transfer, with IR as
// the payload.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start        run request, honoured only in IDLE or HALT
//   Instruction  combinational program-memory read data at address PC
//   zero_flag    datapath zero flag, sampled only in DECODE
//   exec_ready   datapath accepts the current exec transfer
//   PC           program-memory address (registered)
//   IR           instruction register (registered)
//   exec_valid   IR holds a datapath op awaiting acceptance
//   halted       high exactly while in HALT
//   busy         high in FETCH, DECODE or EXEC
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// FETCH  | IR <= Instruction at current PC
// DECODE | resolve control flow, or hand a datapath op to EXEC
// EXEC   | exec_valid high, waiting for exec_ready
// HALT   | HLT executed, start restarts the program from address 0
// ----------------------------------------------------------------------------
module instruction_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] Instruction,
   input  logic       zero_flag,
   input  logic       exec_ready,
   output logic [3:0] PC,
   output logic [7:0] IR,
   output logic       exec_valid,
   output logic       halted,
   output logic       busy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] HALT   = 3'd4;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_JZ  = 4'hD;
   localparam logic [3:0] OP_JMP = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [2:0] state;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [3:0] pc_inc;

   assign opcode  = IR[7:4];
   assign operand = IR[3:0];
   // 4-bit result, so 15 wraps to 0
   assign pc_inc  = PC + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         PC    <= 4'd0;
         IR    <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= FETCH;
            end
            FETCH: begin
               IR    <= Instruction;
               state <= DECODE;
            end
            DECODE: begin
               case (opcode)
                  OP_NOP: begin
                     PC    <= pc_inc;
                     state <= FETCH;
                  end
                  OP_JMP: begin
                     PC    <= operand;
                     state <= FETCH;
                  end
                  OP_JZ: begin
                     PC    <= zero_flag ? operand : pc_inc;
                     state <= FETCH;
                  end
                  OP_HLT: begin
                     state <= HALT;
                  end
                  default: begin
                     state <= EXEC;
                  end
               endcase
            end
            EXEC: begin
               // IR is not written here, so the payload is stable while valid
               if (exec_ready) begin
                  PC    <= pc_inc;
                  state <= FETCH;
               end
            end
            HALT: begin
               if (start) begin
                  PC    <= 4'd0;
                  state <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign exec_valid = (state == EXEC);
   assign halted     = (state == HALT);
   assign busy       = (state == FETCH) || (state == DECODE) || (state == EXEC);

endmodule

// File: tb/tb_instruction_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instruction_sequencer
//
// Directed scenarios plus random programs, checked against an
// instruction-level model of the program.
// ----------------------------------------------------------------------------
module tb_instruction_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] Instruction;
   logic       zero_flag;
   logic       exec_ready;
   logic [3:0] PC;
   logic [7:0] IR;
   logic       exec_valid;
   logic       halted;
   logic       busy;

   logic [7:0] prog [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign Instruction = prog[PC];

   instruction_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .Instruction (Instruction),
      .zero_flag   (zero_flag),
      .exec_ready  (exec_ready),
      .PC          (PC),
      .IR          (IR),
      .exec_valid  (exec_valid),
      .halted      (halted),
      .busy        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      exec_ready = 1'b0;
      zero_flag  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      clear_prog();
      rst        = 1'b1;
      start      = 1'b1;
      exec_ready = 1'b1;
      zero_flag  = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if ({PC, IR, exec_valid, halted, busy} !== {4'h0, 8'h00, 3'b000}) begin
         errors++;
         $display("FAIL reset_held: PC=%h IR=%h v/h/b=%b%b%b, required 0 00 000",
                  PC, IR, exec_valid, halted, busy);
      end
      rst   = 1'b0;
      start = 1'b0;
      tick();
      tick();
      checks++;
      if ({PC, busy, halted} !== {4'h0, 2'b00}) begin
         errors++;
         $display("FAIL reset_idle_no_start: PC=%h busy=%b halted=%b, required 0 0 0",
                  PC, busy, halted);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_basic();
      logic [3:0] pcs[$];
      int nvalid;
      int cyc;
      logic [7:0] irv;
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = 8'h12; prog[1] = 8'h00; prog[2] = 8'hF0;
      exec_ready = 1'b1;
      nvalid = 0;
      irv = 8'hxx;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      pcs.push_back(PC);
      while (!halted && cyc < 8) begin
         if (exec_valid) begin
            nvalid++;
            irv = IR;
         end
         tick();
         cyc++;
         if (PC != pcs[pcs.size()-1]) pcs.push_back(PC);
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL basic_halt_time: halted=%b after %0d cycles, required 1 within 8", halted, cyc);
      end
      checks++;
      if (nvalid != 1 || irv !== 8'h12) begin
         errors++;
         $display("FAIL basic_exec_pulse: %0d pulses IR=%h, required 1 pulse IR=12", nvalid, irv);
      end
      ok = (pcs.size() == 3);
      if (ok) ok = (pcs[0] == 4'd0) && (pcs[1] == 4'd1) && (pcs[2] == 4'd2);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_pc_trace: %0d distinct PCs, last %h, required 0,1,2",
                  pcs.size(), pcs[pcs.size()-1]);
      end
      repeat (4) tick();
      checks++;
      if ({halted, PC, busy} !== {1'b1, 4'd2, 1'b0}) begin
         errors++;
         $display("FAIL basic_halt_hold: halted=%b PC=%h busy=%b, required 1 2 0", halted, PC, busy);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_branch(input logic zf, input logic [3:0] final_pc);
      logic [3:0] pcs[$];
      int cyc;
      bit ok;
      do_reset();
      clear_prog();
      prog[0] = 8'hE5; prog[5] = 8'hD9; prog[6] = 8'hF0; prog[9] = 8'hF0;
      zero_flag = zf;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      pcs.push_back(PC);
      while (!halted && cyc < 20) begin
         tick();
         cyc++;
         if (PC != pcs[pcs.size()-1]) pcs.push_back(PC);
      end
      ok = (pcs.size() == 3) && halted;
      if (ok) ok = (pcs[0] == 4'd0) && (pcs[1] == 4'd5) && (pcs[2] == final_pc);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL branch_zf%0b: %0d PCs last %h halted=%b, required 0,5,%h halted",
                  zf, pcs.size(), PC, halted, final_pc);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_stall();
      int n;
      do_reset();
      clear_prog();
      prog[3] = 8'h47; prog[4] = 8'hF0;
      exec_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!exec_valid && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if ({exec_valid, PC, IR} !== {1'b1, 4'd3, 8'h47}) begin
         errors++;
         $display("FAIL stall_enter: valid=%b PC=%h IR=%h, required 1 3 47", exec_valid, PC, IR);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({exec_valid, PC, IR} !== {1'b1, 4'd3, 8'h47}) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b PC=%h IR=%h, required 1 3 47",
                     i, exec_valid, PC, IR);
         end
      end
      exec_ready = 1'b1;
      tick();
      checks++;
      if ({exec_valid, PC} !== {1'b0, 4'd4}) begin
         errors++;
         $display("FAIL stall_handshake: valid=%b PC=%h, required 0 4", exec_valid, PC);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_wrap();
      int n;
      bit saw15;
      do_reset();
      clear_prog();
      prog[0] = 8'hEF;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      // JMP 15 is in IR now; the word at address 0 becomes HLT for the wrap
      prog[0] = 8'hF0;
      n = 0;
      saw15 = 1'b0;
      while (!halted && n < 20) begin
         tick();
         n++;
         if (PC == 4'd15) saw15 = 1'b1;
      end
      checks++;
      if (!saw15 || {halted, PC} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL wrap: saw15=%b halted=%b PC=%h, required 1 1 0", saw15, halted, PC);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_in_exec();
      int n;
      do_reset();
      clear_prog();
      prog[0] = 8'h00; prog[1] = 8'hA3;
      exec_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!exec_valid && n < 20) begin
         tick();
         n++;
      end
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({exec_valid, busy, halted, PC, IR} !== {3'b000, 4'd0, 8'h00}) begin
         errors++;
         $display("FAIL reset_in_exec: v/b/h=%b%b%b PC=%h IR=%h, required 000 0 00",
                  exec_valid, busy, halted, PC, IR);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, PC} !== {1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset_in_exec_idle: busy=%b PC=%h, required 0 0", busy, PC);
      end
      prog[0] = 8'h5C;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({busy, PC, IR} !== {1'b1, 4'd0, 8'h5C}) begin
         errors++;
         $display("FAIL reset_restart_fetch: busy=%b PC=%h IR=%h, required 1 0 5C", busy, PC, IR);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_halt_restart();
      do_reset();
      clear_prog();
      prog[0] = 8'h47; prog[1] = 8'hF0;
      exec_ready = 1'b0;
      start = 1'b1;           // held high the whole time
      tick();                 // FETCH
      tick();                 // DECODE
      tick();                 // EXEC
      tick();
      tick();
      checks++;
      if ({exec_valid, PC, IR} !== {1'b1, 4'd0, 8'h47}) begin
         errors++;
         $display("FAIL start_ignored_exec: valid=%b PC=%h IR=%h, required 1 0 47", exec_valid, PC, IR);
      end
      exec_ready = 1'b1;
      tick();                 // FETCH @1
      tick();                 // DECODE HLT
      tick();                 // HALT
      checks++;
      if ({halted, PC} !== {1'b1, 4'd1}) begin
         errors++;
         $display("FAIL halt_reached: halted=%b PC=%h, required 1 1", halted, PC);
      end
      tick();
      checks++;
      if ({halted, busy, PC} !== {1'b0, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL halt_restart: halted=%b busy=%b PC=%h, required 0 1 0", halted, busy, PC);
      end
      tick();
      checks++;
      if (IR !== 8'h47) begin
         errors++;
         $display("FAIL halt_restart_fetch: IR=%h, required 47", IR);
      end
      start = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Instruction-level model: walks the program one instruction at a time and
   // accumulates its cost (2 cycles for control flow, 3 for a datapath op with
   // exec_ready held high).
   task automatic test_random(input int iters);
      logic [7:0] exp_ops[$];
      logic [7:0] got_ops[$];
      logic [3:0] mpc;
      logic [7:0] ins;
      logic       zf;
      bit         mhalt;
      int         cyc;
      int         ninst;
      int         r;
      bit         ok;
      for (int it = 0; it < iters; it++) begin
         do_reset();
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            case (r)
               0: prog[i] = {4'h0, 4'($urandom_range(0, 15))};
               1: prog[i] = {4'hD, 4'($urandom_range(0, 15))};
               2: prog[i] = {4'hE, 4'($urandom_range(0, 15))};
               3: prog[i] = {4'hF, 4'($urandom_range(0, 15))};
               default: prog[i] = {4'($urandom_range(1, 12)), 4'($urandom_range(0, 15))};
            endcase
         end
         zf = 1'($urandom_range(0, 1));
         exp_ops.delete();
         got_ops.delete();
         mpc = 4'd0;
         mhalt = 1'b0;
         cyc = 1;
         ninst = 0;
         while (!mhalt && ninst < 40) begin
            ins = prog[mpc];
            cyc += 2;
            if (ins[7:4] == 4'h0) mpc = mpc + 4'd1;
            else if (ins[7:4] == 4'hD) mpc = zf ? ins[3:0] : mpc + 4'd1;
            else if (ins[7:4] == 4'hE) mpc = ins[3:0];
            else if (ins[7:4] == 4'hF) mhalt = 1'b1;
            else begin
               exp_ops.push_back(ins);
               mpc = mpc + 4'd1;
               cyc += 1;
            end
            ninst++;
         end
         zero_flag  = zf;
         exec_ready = 1'b1;
         start = 1'b1;
         for (int k = 0; k < cyc; k++) begin
            tick();
            start = 1'b0;
            if (exec_valid && exec_ready) got_ops.push_back(IR);
         end
         checks++;
         if ({halted, busy, PC} !== {mhalt, !mhalt, mpc}) begin
            errors++;
            $display("FAIL random%0d_end: halted=%b busy=%b PC=%h, required %b %b %h",
                     it, halted, busy, PC, mhalt, !mhalt, mpc);
         end
         ok = (got_ops.size() == exp_ops.size());
         if (ok) begin
            for (int i = 0; i < exp_ops.size(); i++)
               if (got_ops[i] !== exp_ops[i]) ok = 1'b0;
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL random%0d_ops: %0d transfers seen, required %0d in model order",
                     it, got_ops.size(), exp_ops.size());
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      exec_ready = 1'b0;
      zero_flag  = 1'b0;
      test_reset();
      test_basic();
      test_branch(1'b1, 4'd9);
      test_branch(1'b0, 4'd6);
      test_stall();
      test_wrap();
      test_reset_in_exec();
      test_halt_restart();
      test_random(30);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
